// File: rtl/enum_type.sv
// Game-wide enumerations shared by the tetris control path.
package enum_type;

    typedef logic [3:0] state_type;

endpackage

// File: rtl/uart_pkg.sv
// UART helpers: ASCII constants, hex digit encoding, bit-time computation, FSM state types.
package uart_pkg;

    localparam logic [7:0] ASCII_S  = 8'h53;
    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic {
        RPT_IDLE,
        RPT_SEND
    } rpt_state_t;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

    function automatic logic [7:0] hex2ascii(input logic [3:0] d);
        if (d < 4'd10)
            return ASCII_0 + {4'h0, d};
        else
            return ASCII_A + {4'h0, d} - 8'd10;
    endfunction

endpackage

// File: rtl/tetris_uart_reporter_if.sv
// Status/serial bundle between the game core and the UART reporter.
interface tetris_uart_reporter_if;
    import enum_type::*;

    state_type   state;
    logic [15:0] score;
    logic        report;
    logic        uart_tx;
    logic        busy;
    logic        done;

    modport master (
        output state, score, report,
        input  uart_tx, busy, done
    );

    modport slave (
        input  state, score, report,
        output uart_tx, busy, done
    );

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser; ready rises in the final stop-bit cycle so bytes chain without gaps.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]   r_bit;
    logic [7:0]   r_shift;
    logic         r_tx;
    logic         w_last_clk;

    assign w_last_clk = (r_cnt == CNT_LAST);
    assign tx         = r_tx;

    always_comb begin
        ready = 1'b0;
        if (r_state == TX_IDLE || (r_state == TX_STOP && w_last_clk))
            ready = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= TX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    r_tx <= 1'b1;
                    if (valid) begin
                        r_shift <= data;
                        r_cnt   <= '0;
                        r_tx    <= 1'b0;
                        r_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (w_last_clk) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= TX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (w_last_clk) begin
                        r_cnt <= '0;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= TX_STOP;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_tx    <= r_shift[1];
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (w_last_clk) begin
                        r_cnt <= '0;
                        // Accepting here skips IDLE so the next start bit follows immediately
                        if (valid) begin
                            r_shift <= data;
                            r_tx    <= 1'b0;
                            r_state <= TX_START;
                        end else begin
                            r_state <= TX_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/tetris_uart_reporter.sv
// Sends "S<state> <score>\n" over UART whenever state/score change or a report is requested.
module tetris_uart_reporter
    import uart_pkg::*;
    import enum_type::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic                    clk,
    input  logic                    reset,
    tetris_uart_reporter_if.slave   bus
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);

    rpt_state_t  r_state;
    logic        r_busy;
    logic        r_done;
    logic        r_pend;
    logic [19:0] r_last;
    logic [7:0]  r_msg [0:7];
    logic [2:0]  r_idx;

    logic [19:0] w_snap;
    logic        w_trigger;
    logic        w_valid;
    logic        w_ready;
    logic [7:0]  w_data;
    logic        w_tx;

    assign w_snap    = {bus.state, bus.score};
    assign w_trigger = (r_state == RPT_IDLE) && (bus.report || r_pend || (w_snap != r_last));

    // Byte 0 is offered straight from the trigger so the start bit lands the cycle after it
    always_comb begin
        w_valid = 1'b0;
        w_data  = ASCII_S;
        if (r_state == RPT_IDLE) begin
            w_valid = w_trigger;
        end else if (w_ready && r_idx != 3'd7) begin
            w_valid = 1'b1;
            w_data  = r_msg[r_idx + 3'd1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RPT_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pend  <= 1'b0;
            r_last  <= '0;
            r_idx   <= '0;
            for (int unsigned i = 0; i < 8; i++)
                r_msg[i] <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                RPT_IDLE: begin
                    if (w_trigger) begin
                        r_state  <= RPT_SEND;
                        r_busy   <= 1'b1;
                        r_pend   <= 1'b0;
                        r_last   <= w_snap;
                        r_idx    <= '0;
                        r_msg[0] <= ASCII_S;
                        r_msg[1] <= hex2ascii(bus.state);
                        r_msg[2] <= ASCII_SP;
                        r_msg[3] <= hex2ascii(bus.score[15:12]);
                        r_msg[4] <= hex2ascii(bus.score[11:8]);
                        r_msg[5] <= hex2ascii(bus.score[7:4]);
                        r_msg[6] <= hex2ascii(bus.score[3:0]);
                        r_msg[7] <= ASCII_LF;
                    end
                end
                RPT_SEND: begin
                    if (bus.report)
                        r_pend <= 1'b1;
                    if (w_ready) begin
                        if (r_idx != 3'd7) begin
                            r_idx <= r_idx + 3'd1;
                        end else begin
                            r_state <= RPT_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= RPT_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk   (clk),
        .reset (reset),
        .data  (w_data),
        .valid (w_valid),
        .ready (w_ready),
        .tx    (w_tx)
    );

    assign bus.uart_tx = w_tx;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;

endmodule

// File: tb/tb_tetris_uart_reporter.sv
// Directed bench: decodes UART frames at mid-bit and checks bytes, timing, done and reset behaviour.
module tb_tetris_uart_reporter;

    localparam int unsigned CPB = 10;

    logic clk;
    logic reset;
    int unsigned n_checks;
    int unsigned n_fail;

    tetris_uart_reporter_if bus();

    tetris_uart_reporter #(
        .CLK_HZ(1000),
        .BAUD  (100)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expects the start bit to be at most 3000 cycles away; leaves caller on the negedge where done should be high
    task automatic rx_frame(input string tag, input logic [63:0] exp);
        logic [63:0] got;
        logic [7:0]  b;
        int unsigned w;
        int unsigned bad;
        got = '0;
        b   = '0;
        w   = 0;
        bad = 0;
        while (bus.uart_tx !== 1'b0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (bus.uart_tx !== 1'b0) begin
            check_eq({tag, "_start_timeout"}, 64'(bus.uart_tx), 64'd0);
            return;
        end
        repeat (CPB / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) repeat (CPB) @(negedge clk);
            if (bus.uart_tx !== 1'b0 || bus.busy !== 1'b1) bad++;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                b[i] = bus.uart_tx;
                if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
            end
            repeat (CPB) @(negedge clk);
            if (bus.uart_tx !== 1'b1) bad++;
            got = {got[55:0], b};
        end
        check_eq({tag, "_framing"}, 64'(bad), 64'd0);
        check_eq({tag, "_bytes"}, got, exp);
        repeat (CPB / 2 - 1) @(negedge clk);
        check_eq({tag, "_done_early"}, 64'(bus.done), 64'd0);
        @(negedge clk);
        check_eq({tag, "_done"}, 64'(bus.done), 64'd1);
        check_eq({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic idle_check(input string tag, input int unsigned n);
        int unsigned act;
        act = 0;
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.uart_tx !== 1'b1) act++;
        end
        check_eq(tag, 64'(act), 64'd0);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        bus.state  = 4'h0;
        bus.score  = 16'h0000;
        bus.report = 1'b0;

        // 1: reset values and quiet line with zero values
        repeat (3) @(negedge clk);
        check_eq("rst_tx", 64'(bus.uart_tx), 64'd1);
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_done", 64'(bus.done), 64'd0);
        reset = 1'b0;
        idle_check("quiet_2000", 2000);

        // 2: score change -> frame, start bit the cycle after the trigger
        bus.score = 16'h01A3;
        @(negedge clk);
        check_eq("t2_start_lat", 64'(bus.uart_tx), 64'd0);
        check_eq("t2_busy", 64'(bus.busy), 64'd1);
        rx_frame("t2", 64'h533020303141330A);
        idle_check("t2_no_more", 200);

        // 3: report with unchanged values, plus a report while busy
        bus.state = 4'h2;
        bus.score = 16'h0000;
        rx_frame("t3_chg", 64'h533220303030300A);
        repeat (20) @(negedge clk);
        bus.report = 1'b1;
        @(negedge clk);
        bus.report = 1'b0;
        check_eq("t3_rep_lat", 64'(bus.uart_tx), 64'd0);
        fork
            rx_frame("t3_rep1", 64'h533220303030300A);
            begin
                repeat (200) @(negedge clk);
                bus.report = 1'b1;
                @(negedge clk);
                bus.report = 1'b0;
            end
        join
        @(negedge clk);
        check_eq("t3_gap", 64'(bus.uart_tx), 64'd0);
        rx_frame("t3_rep2", 64'h533220303030300A);
        idle_check("t3_no_more", 1000);

        // 4: changes during a frame do not touch bytes in flight; one follow-up frame
        bus.score = 16'h0005;
        @(negedge clk);
        check_eq("t4_start_lat", 64'(bus.uart_tx), 64'd0);
        fork
            rx_frame("t4_s5", 64'h533220303030350A);
            begin
                repeat (100) @(negedge clk);
                bus.score = 16'h0006;
                repeat (100) @(negedge clk);
                bus.score = 16'h0007;
            end
        join
        @(negedge clk);
        check_eq("t4_gap", 64'(bus.uart_tx), 64'd0);
        rx_frame("t4_s7", 64'h533220303030370A);
        idle_check("t4_no_more", 1000);

        // 5: change and report in the same cycle -> single frame
        bus.state  = 4'hB;
        bus.score  = 16'hFFFF;
        bus.report = 1'b1;
        @(negedge clk);
        bus.report = 1'b0;
        check_eq("t5_start_lat", 64'(bus.uart_tx), 64'd0);
        rx_frame("t5", 64'h534220464646460A);
        idle_check("t5_no_dup", 1000);

        // 6: reset during byte 3 start bit, then re-report after release
        bus.score = 16'h1234;
        @(negedge clk);
        check_eq("t6_start_lat", 64'(bus.uart_tx), 64'd0);
        repeat (305) @(negedge clk);
        check_eq("t6_pre_rst_tx", 64'(bus.uart_tx), 64'd0);
        #1 reset = 1'b1;
        #1;
        check_eq("t6_rst_tx", 64'(bus.uart_tx), 64'd1);
        check_eq("t6_rst_busy", 64'(bus.busy), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rx_frame("t6_resend", 64'h534220313233340A);
        idle_check("t6_no_more", 300);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
